// File: rtl/battle_pkg.sv
// Shared types and constants for the tank and shell blocks.
// Key codes, playfield bounds, facing and fire-state enums.
package battle_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      READY,
      LAUNCH,
      FLYING,
      COOLDOWN
   } fire_state_t;

   localparam logic [7:0] KEY_W    = 8'h1A;
   localparam logic [7:0] KEY_S    = 8'h16;
   localparam logic [7:0] KEY_A    = 8'h04;
   localparam logic [7:0] KEY_D    = 8'h07;
   localparam logic [7:0] KEY_FIRE = 8'h2C;

   localparam int X_MIN = 0;
   localparam int X_MAX = 639;
   localparam int Y_MIN = 0;
   localparam int Y_MAX = 479;

endpackage

// File: rtl/tank_fire_fsm.sv
// Fire arbitration: Space edge detect, launch/flight/cooldown FSM.
// A shell is only requested from READY; all other presses are dropped.
module tank_fire_fsm
   import battle_pkg::*;
#(
   parameter int FIRE_COOLDOWN  = 30,
   parameter int LAUNCH_TIMEOUT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic fire_key_i,
   input  logic shell_flying_i,
   output logic fire_o,
   output logic fire_ready_o
);

   localparam int CW = $clog2(FIRE_COOLDOWN + 1);
   localparam int LW = $clog2(LAUNCH_TIMEOUT + 1);
   localparam logic [CW-1:0] CD_LOAD = CW'(FIRE_COOLDOWN - 1);
   localparam logic [LW-1:0] LT_LAST = LW'(LAUNCH_TIMEOUT - 1);

   fire_state_t   state_q;
   logic          prev_q;
   logic          fire_q;
   logic          ready_q;
   logic [CW-1:0] cd_q;
   logic [LW-1:0] lt_q;
   logic          edge_w;

   assign edge_w       = fire_key_i & ~prev_q;
   assign fire_o       = fire_q;
   assign fire_ready_o = ready_q;

   // Fire FSM with registered pulse and ready flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= READY;
         prev_q  <= 1'b0;
         fire_q  <= 1'b0;
         ready_q <= 1'b1;
         cd_q    <= '0;
         lt_q    <= '0;
      end else begin
         prev_q <= fire_key_i;
         fire_q <= 1'b0;
         unique case (state_q)
            READY: begin
               if (edge_w && !shell_flying_i) begin
                  fire_q  <= 1'b1;
                  lt_q    <= '0;
                  state_q <= LAUNCH;
                  ready_q <= 1'b0;
               end
            end
            LAUNCH: begin
               if (shell_flying_i) begin
                  state_q <= FLYING;
               end else if (lt_q == LT_LAST) begin
                  cd_q    <= CD_LOAD;
                  state_q <= COOLDOWN;
               end else begin
                  lt_q <= lt_q + 1'b1;
               end
            end
            FLYING: begin
               if (!shell_flying_i) begin
                  cd_q    <= CD_LOAD;
                  state_q <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (cd_q == '0) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end else begin
                  cd_q <= cd_q - 1'b1;
               end
            end
            default: state_q <= READY;
         endcase
      end
   end

endmodule

// File: rtl/tank_ctrl.sv
// Player tank: key decode, turn-then-move motion with edge clamp,
// and the fire arbiter feeding the shell block.
module tank_ctrl
   import battle_pkg::*;
#(
   parameter int TANK_X_START   = 320,
   parameter int TANK_Y_START   = 400,
   parameter int TANK_HALF      = 16,
   parameter int STEP           = 1,
   parameter int FIRE_COOLDOWN  = 30,
   parameter int LAUNCH_TIMEOUT = 4
) (
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [15:0] keycode,
   input  logic        shell_flying,
   output logic [9:0]  TankX,
   output logic [9:0]  TankY,
   output logic [2:0]  direction,
   output logic        fire,
   output logic        tank_moving,
   output logic        fire_ready
);

   localparam logic [10:0] XLO = 11'(X_MIN + TANK_HALF);
   localparam logic [10:0] XHI = 11'(X_MAX - TANK_HALF);
   localparam logic [10:0] YLO = 11'(Y_MIN + TANK_HALF);
   localparam logic [10:0] YHI = 11'(Y_MAX - TANK_HALF);
   localparam logic [10:0] STP = 11'(STEP);

   logic [9:0]  x_q, x_d, y_q, y_d;
   dir_t        dir_q, dir_d, req_dir;
   logic        mov_q, mov_d;
   logic        req_vld, fire_key;
   logic [10:0] xw, yw;
   logic [7:0]  lo, hi;

   function automatic logic is_move(input logic [7:0] b);
      return (b == KEY_W) || (b == KEY_S) ||
             (b == KEY_A) || (b == KEY_D);
   endfunction

   function automatic dir_t key_dir(input logic [7:0] b);
      dir_t d;
      d = UP;
      if (b == KEY_S) d = DOWN;
      if (b == KEY_A) d = LEFT;
      if (b == KEY_D) d = RIGHT;
      return d;
   endfunction

   assign lo = keycode[7:0];
   assign hi = keycode[15:8];
   assign xw = {1'b0, x_q};
   assign yw = {1'b0, y_q};
   assign fire_key = (lo == KEY_FIRE) || (hi == KEY_FIRE);

   // Move request: the low byte wins over the high byte.
   always_comb begin
      req_vld = 1'b1;
      req_dir = UP;
      if (is_move(lo))      req_dir = key_dir(lo);
      else if (is_move(hi)) req_dir = key_dir(hi);
      else                  req_vld = 1'b0;
   end

   // Turn in place on a new heading; otherwise step and clamp.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      dir_d = dir_q;
      if (req_vld && req_dir != dir_q) begin
         dir_d = req_dir;
      end else if (req_vld) begin
         unique case (dir_q)
            UP: begin
               if (yw >= YLO + STP)  y_d = 10'(yw - STP);
               else if (yw > YLO)    y_d = YLO[9:0];
            end
            DOWN: begin
               if (yw + STP <= YHI)  y_d = 10'(yw + STP);
               else if (yw < YHI)    y_d = YHI[9:0];
            end
            LEFT: begin
               if (xw >= XLO + STP)  x_d = 10'(xw - STP);
               else if (xw > XLO)    x_d = XLO[9:0];
            end
            RIGHT: begin
               if (xw + STP <= XHI)  x_d = 10'(xw + STP);
               else if (xw < XHI)    x_d = XHI[9:0];
            end
            default: ;
         endcase
      end
      mov_d = (x_d != x_q) || (y_d != y_q);
   end

   // Tank position, heading and motion flag registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         x_q   <= 10'(TANK_X_START);
         y_q   <= 10'(TANK_Y_START);
         dir_q <= UP;
         mov_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         dir_q <= dir_d;
         mov_q <= mov_d;
      end
   end

   tank_fire_fsm #(
      .FIRE_COOLDOWN  (FIRE_COOLDOWN),
      .LAUNCH_TIMEOUT (LAUNCH_TIMEOUT)
   ) u_fire (
      .clk_i          (frame_clk),
      .rst_i          (Reset),
      .fire_key_i     (fire_key),
      .shell_flying_i (shell_flying),
      .fire_o         (fire),
      .fire_ready_o   (fire_ready)
   );

   assign TankX       = x_q;
   assign TankY       = y_q;
   assign direction   = {1'b0, dir_q};
   assign tank_moving = mov_q;

endmodule

// File: tb/tb_tank_ctrl.sv
// Bench for tank_ctrl: directed scenarios plus random keycodes,
// all checked against a frame-level behavioural model.
module tb_tank_ctrl;

   logic        Reset;
   logic        frame_clk;
   logic [15:0] keycode;
   logic        shell_flying;
   logic [9:0]  TankX, TankY;
   logic [2:0]  direction;
   logic        fire, tank_moving, fire_ready;

   int checks = 0;
   int fails  = 0;

   tank_ctrl dut (
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .keycode      (keycode),
      .shell_flying (shell_flying),
      .TankX        (TankX),
      .TankY        (TankY),
      .direction    (direction),
      .fire         (fire),
      .tank_moving  (tank_moving),
      .fire_ready   (fire_ready)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   // Model state: plain integers, one update per frame.
   int m_x, m_y, m_dir, m_mov, m_fire, m_rdy, m_prev;
   int m_phase, m_waited, m_remain;
   localparam int PH_IDLE = 0, PH_WAIT = 1;
   localparam int PH_AIR = 2, PH_REST = 3;

   task automatic m_reset();
      m_x = 320; m_y = 400; m_dir = 0; m_mov = 0;
      m_fire = 0; m_rdy = 1; m_prev = 0;
      m_phase = PH_IDLE; m_waited = 0; m_remain = 0;
   endtask

   function automatic int key2dir(input logic [7:0] b);
      case (b)
         8'h1A: return 0;
         8'h16: return 1;
         8'h04: return 2;
         8'h07: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic m_frame(input logic [15:0] kc, input logic sf);
      int r, nx, ny, fk, pressed;
      logic [7:0] lo, hi;
      lo = kc[7:0];
      hi = kc[15:8];
      r = key2dir(lo);
      if (r < 0) r = key2dir(hi);
      nx = m_x; ny = m_y;
      if (r >= 0 && r != m_dir) m_dir = r;
      else if (r == 0) ny = (m_y - 1 < 16) ? m_y : m_y - 1;
      else if (r == 1) ny = (m_y + 1 > 463) ? m_y : m_y + 1;
      else if (r == 2) nx = (m_x - 1 < 16) ? m_x : m_x - 1;
      else if (r == 3) nx = (m_x + 1 > 623) ? m_x : m_x + 1;
      m_mov = (nx != m_x || ny != m_y) ? 1 : 0;
      m_x = nx; m_y = ny;
      fk = (lo == 8'h2C || hi == 8'h2C) ? 1 : 0;
      pressed = fk && !m_prev;
      m_prev = fk;
      m_fire = 0;
      if (m_phase == PH_IDLE) begin
         if (pressed && !sf) begin
            m_fire = 1; m_phase = PH_WAIT; m_waited = 0;
         end
      end else if (m_phase == PH_WAIT) begin
         if (sf) m_phase = PH_AIR;
         else begin
            m_waited++;
            if (m_waited == 4) begin
               m_phase = PH_REST; m_remain = 30;
            end
         end
      end else if (m_phase == PH_AIR) begin
         if (!sf) begin m_phase = PH_REST; m_remain = 30; end
      end else begin
         m_remain--;
         if (m_remain == 0) m_phase = PH_IDLE;
      end
      m_rdy = (m_phase == PH_IDLE) ? 1 : 0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      chk("TankX", 16'(TankX), 16'(m_x));
      chk("TankY", 16'(TankY), 16'(m_y));
      chk("direction", 16'(direction), 16'(m_dir));
      chk("tank_moving", 16'(tank_moving), 16'(m_mov));
      chk("fire", 16'(fire), 16'(m_fire));
      chk("fire_ready", 16'(fire_ready), 16'(m_rdy));
   endtask

   task automatic step(input logic [15:0] kc, input logic sf);
      keycode = kc;
      shell_flying = sf;
      @(posedge frame_clk);
      m_frame(kc, sf);
      #1 cmp_all();
   endtask

   function automatic logic [7:0] rnd_byte();
      case ($urandom_range(0, 6))
         0: return 8'h00;
         1: return 8'h1A;
         2: return 8'h16;
         3: return 8'h04;
         4: return 8'h07;
         5: return 8'h2C;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"}, 16'(TankX), 16'd320);
      chk({tag, "_y"}, 16'(TankY), 16'd400);
      chk({tag, "_dir"}, 16'(direction), 16'd0);
      chk({tag, "_fire"}, 16'(fire), 16'd0);
      chk({tag, "_mov"}, 16'(tank_moving), 16'd0);
      chk({tag, "_rdy"}, 16'(fire_ready), 16'd1);
   endtask

   initial begin
      int n, pulses;
      logic sf;
      Reset = 1'b1;
      keycode = '0;
      shell_flying = 1'b0;
      m_reset();
      repeat (2) @(posedge frame_clk);
      #1 chk_reset_vals("rst");
      Reset = 1'b0;

      // Idle frames hold reset values.
      repeat (5) begin
         step(16'h0000, 1'b0);
         chk_reset_vals("idle");
      end

      // D: turn first, then three steps right.
      step(16'h0007, 1'b0);
      chk("d_turn_dir", 16'(direction), 16'd3);
      chk("d_turn_x", 16'(TankX), 16'd320);
      step(16'h0007, 1'b0);
      chk("d_x1", 16'(TankX), 16'd321);
      step(16'h0007, 1'b0);
      chk("d_x2", 16'(TankX), 16'd322);
      step(16'h0007, 1'b0);
      chk("d_x3", 16'(TankX), 16'd323);
      chk("d_mov", 16'(tank_moving), 16'd1);

      // Hold A into the left clamp.
      repeat (320) step(16'h0004, 1'b0);
      chk("clamp_x", 16'(TankX), 16'd16);
      chk("clamp_mov", 16'(tank_moving), 16'd0);

      // Space held, shell flies 5 frames, extra presses in cooldown.
      step(16'h0000, 1'b0);
      step(16'h002C, 1'b0);
      chk("fire1", 16'(fire), 16'd1);
      pulses = 0;
      repeat (5) begin
         step(16'h002C, 1'b1);
         pulses += int'(fire);
      end
      n = 0;
      do begin
         n++;
         if (n <= 4 || n == 12) step(16'h002C, 1'b0);
         else step(16'h0000, 1'b0);
         pulses += int'(fire);
      end while (!fire_ready && n < 60);
      chk("no_refire", 16'(pulses), 16'd0);
      chk("cd_len", 16'(n), 16'd31);

      // Fresh press after re-arm; shell never reports flying.
      step(16'h002C, 1'b0);
      chk("fire2", 16'(fire), 16'd1);
      n = 0;
      do begin
         n++;
         step(16'h0000, 1'b0);
      end while (!fire_ready && n < 60);
      chk("timeout_len", 16'(n), 16'd34);

      // Fire blocked while a shell is already flying.
      step(16'h002C, 1'b1);
      chk("blocked", 16'(fire), 16'd0);
      step(16'h0000, 1'b0);

      // Low byte wins; turn and fire in one frame.
      step(16'h1604, 1'b0);
      chk("lowwins", 16'(direction), 16'd2);
      step(16'h0000, 1'b0);
      step(16'h2C1A, 1'b0);
      chk("turnfire_dir", 16'(direction), 16'd0);
      chk("turnfire_fire", 16'(fire), 16'd1);

      // Random frames with occasional async reset mid-frame.
      sf = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) sf = ~sf;
         step({rnd_byte(), rnd_byte()}, sf);
         if (i % 500 == 250) begin
            #2 Reset = 1'b1;
            #1 chk_reset_vals("async");
            m_reset();
            @(posedge frame_clk);
            #1 Reset = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
